// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helpers for the serial BCD add/subtract datapath.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RECOMP = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [3:0] nines(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

  function automatic logic digit_bad(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary sum of two digits plus carry, +6 correction above nine.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] bin;
  logic [4:0] corr;

  assign bin  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
  assign corr = bin + {1'b0, BCD_CORR};
  assign cout = bin > {1'b0, BCD_MAX};
  assign s    = cout ? corr[3:0] : bin[3:0];

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor; one shared digit adder walks LSD to MSD,
// with a second pass that re-complements negative differences to sign-magnitude.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  neg,
  output logic                  invalid
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

  state_t                     state;
  state_t                     state_n;
  logic [DIGITS-1:0][3:0]     a_q;
  logic [DIGITS-1:0][3:0]     b_q;
  logic [DIGITS-1:0][3:0]     result_q;
  logic [DIGITS-1:0][3:0]     a_in;
  logic [DIGITS-1:0][3:0]     b_in;
  logic                       sub_q;
  logic                       carry_q;
  logic [IDXW-1:0]            idx_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       cout_q;
  logic                       neg_q;
  logic                       invalid_q;

  logic                       accept;
  logic                       in_bad;
  logic                       last;
  logic [3:0]                 dx;
  logic [3:0]                 dy;
  logic [3:0]                 dsum;
  logic                       dcout;

  assign a_in = a;
  assign b_in = b;

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_bad(a_in[i]) || digit_bad(b_in[i])) in_bad = 1'b1;
    end
  end

  // The done pulse trails the DONE state by one cycle, so that cycle also refuses start.
  assign accept = (state == IDLE) && start && !done_q;
  assign last   = (idx_q == LAST);

  always_comb begin
    if (state == RECOMP) begin
      dx = nines(result_q[idx_q]);
      dy = 4'd0;
    end else begin
      dx = a_q[idx_q];
      dy = sub_q ? nines(b_q[idx_q]) : b_q[idx_q];
    end
  end

  bcd_digit_add u_digit (
    .x    (dx),
    .y    (dy),
    .cin  (carry_q),
    .s    (dsum),
    .cout (dcout)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = in_bad ? DONE : RUN;
      RUN:     if (last) state_n = (!sub_q || dcout) ? DONE : RECOMP;
      RECOMP:  if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cout_q    <= 1'b0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      busy_q <= (state == RUN) || (state == RECOMP);
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            a_q       <= a_in;
            b_q       <= b_in;
            sub_q     <= sub;
            result_q  <= '0;
            cout_q    <= 1'b0;
            neg_q     <= 1'b0;
            invalid_q <= in_bad;
            idx_q     <= '0;
            carry_q   <= sub;
          end
        end
        RUN: begin
          result_q[idx_q] <= dsum;
          carry_q         <= dcout;
          if (last) begin
            idx_q <= '0;
            if (!sub_q) begin
              cout_q <= dcout;
            end else if (!dcout) begin
              neg_q   <= 1'b1;
              carry_q <= 1'b1;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        RECOMP: begin
          result_q[idx_q] <= dsum;
          carry_q         <= dcout;
          idx_q           <= last ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign neg     = neg_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (DIGITS=4): latency, pulse width, results, reset and start filtering.
module tb_bcd_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        neg;
  logic        invalid;

  int n_chk;
  int n_fail;

  bcd_serial_addsub #(.DIGITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .neg     (neg),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, scramble inputs after the start edge, optionally poke start mid-run,
  // then check done latency, busy duration, pulse width and the returned flags.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tsub, input int exp_edge, input logic [15:0] exp_res,
                       input logic exp_cout, input logic exp_neg, input logic exp_inv,
                       input logic poke);
    int k;
    int done_edge;
    int busy_cnt;
    @(negedge clk);
    a = ta; b = tb_v; sub = tsub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 16'hA5F3; b = 16'h9999; sub = ~tsub;
    done_edge = 0;
    busy_cnt  = 0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (poke && k == 2) begin
        start = 1'b1; a = 16'h0000; b = 16'h0000;
      end
      if (poke && k == 3) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_edge = k;
        break;
      end
    end
    chk({tag, "_latency"}, done_edge, exp_edge);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_edge - 1);
    chk({tag, "_result"}, {16'h0, result}, {16'h0, exp_res});
    chk({tag, "_cout"}, {31'h0, cout}, {31'h0, exp_cout});
    chk({tag, "_neg"}, {31'h0, neg}, {31'h0, exp_neg});
    chk({tag, "_invalid"}, {31'h0, invalid}, {31'h0, exp_inv});
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, {31'h0, done}, 32'h0);
    chk({tag, "_result_hold"}, {16'h0, result}, {16'h0, exp_res});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    sub    = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {12'h0, busy, done, cout, neg, result}, 32'h0);
    chk("reset_invalid", {31'h0, invalid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 5, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("add_zero",      16'h0000, 16'h0000, 1'b0, 5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 5, 16'h3766, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sub_equal",     16'h0456, 16'h0456, 1'b1, 5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sub_negative",  16'h0123, 16'h0456, 1'b1, 9, 16'h0333, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("sub_0_9999",    16'h0000, 16'h9999, 1'b1, 9, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("invalid_a",     16'h12A4, 16'h0001, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op("after_invalid", 16'h0005, 16'h0004, 1'b0, 5, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("start_mid_run", 16'h4321, 16'h8765, 1'b0, 5, 16'h3086, 1'b1, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a run clears everything before any clock edge.
    @(negedge clk);
    a = 16'h0123; b = 16'h0456; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_before_reset", {31'h0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {12'h0, busy, done, cout, neg, result}, 32'h0);
    chk("async_reset_invalid", {31'h0, invalid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("after_reset",   16'h0500, 16'h0250, 1'b1, 5, 16'h0250, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
